hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Sits beside the decode-stage control unit and drives the write-enable, hold and flush controls of the PC and pipeline registers. Inserts load-use bubbles, squashes wrong-path instructions on taken branches and jumps, and sequences a multi-cycle data-memory req/ack handshake with timeout. Keeps a saturating stall-cycle counter.

## Interface
- MEM_TIMEOUT, 15: maximum WAIT cycles before the memory error; 0 disables the timeout.
- STALL_CNT_W, 16: width of the stall counter.
---
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- id_opcode  in  6  instruction[31:26] in ID
- id_rs, id_rt  in  5 each  source register fields in ID
- id_jump  in  1  Jump control of the ID instruction
- ex_mem_read  in  1  ID/EX MemRead
- ex_rt  in  5  ID/EX rt (load destination)
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_read, mem_write  in  1 each  EX/MEM MemRead/MemWrite
- dmem_ack  in  1  data memory completion
- dmem_req  out  1  data memory request (registered)
- dmem_we  out  1  write qualifier for dmem_req (registered)
- pc_write, ifid_write, idex_write  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  zero IF/ID instruction / ID/EX controls next edge
- exmem_hold  out  1  hold EX/MEM
- mem_timeout  out  1  sticky memory error
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0

## Operation
- Memory FSM states: IDLE, WAIT, ERROR.
  - IDLE: if mem_read|mem_write, go to WAIT and latch dmem_we=mem_write.
  - WAIT: dmem_req=1. On dmem_ack, go to IDLE. Otherwise, when the wait counter reaches MEM_TIMEOUT-1, go to ERROR.
  - ERROR: absorbing until reset; mem_timeout=1.
- dmem_ack is ignored outside WAIT. If ack and timeout fall in the same cycle, ack wins.
- freeze = (IDLE & (mem_read|mem_write)) | (WAIT & ~dmem_ack) | ERROR.
  - While frozen: pc_write=ifid_write=idex_write=0, exmem_hold=1, both flushes 0.
- Release cycle: the cycle dmem_ack is seen in WAIT. freeze drops combinationally, and the MEM instruction retires that edge.
- Load-use condition: ex_mem_read & ex_rt≠0 & (ex_rt==id_rs | (ex_rt==id_rt & uses_rt)).
  - uses_rt is true for opcodes 000000, 000100, 000101, 101011.
  - Response: pc_write=0, ifid_write=0, idex_flush=1; one bubble.
- ex_branch_taken: ifid_flush=1, idex_flush=1.
- id_jump: ifid_flush=1.
- Priority: freeze > branch taken > load-use > jump.
  - A load-use stall defers the jump, which is re-evaluated the next cycle.
  - A freeze defers everything; the branch stays in EX and is re-evaluated.
- Defaults when none of the above apply: all enables 1, flushes 0, exmem_hold 0.
- stall_cycles increments on each clock edge where pc_write=0 and reset is low. It saturates at all-ones.

## Timing
- Reset (async, while high):
  - Registered state: FSM IDLE, wait counter 0, dmem_req=0, dmem_we=0, stall_cycles=0, mem_timeout=0.
  - Combinational outputs are gated: all enables 0, flushes 0, exmem_hold 0.
- Reset mid-WAIT: dmem_req drops asynchronously. The in-flight access is abandoned without waiting for ack.
- dmem_req latency:
  - dmem_req rises one cycle after a memory op is present in MEM.
  - It falls on the edge after ack is sampled.
  - dmem_we is stable for the whole WAIT period.
- Wait counter: clears on entry to WAIT and increments each WAIT cycle. Width is $clog2(MEM_TIMEOUT+1).
- Back-to-back memory ops: one IDLE freeze cycle is inserted between accesses, so dmem_req never stays high across two accesses.
- The hazard, flush and enable outputs are combinational from the inputs and FSM state, with zero latency.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the opcode localparams (R-type, ADDI, LW, SW, J, BEQ, BNE), shared with the control unit;
  - the `mem_state_t` enum (IDLE/WAIT/ERROR).
- Sub-module `dmem_handshake_fsm` owns the FSM, wait counter, dmem_req/dmem_we and mem_timeout, and exports `freeze`.
- The top level holds the hazard/flush logic and stall_cycles.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8; ID add (000000), id_rs=8.
  - Expect one cycle of pc_write=0, ifid_write=0, idex_flush=1, and stall_cycles 0→1.
  - Repeat with ex_rt=0: expect no stall.
- Store with ack on the 3rd WAIT cycle.
  - Expect dmem_req=1 and dmem_we=1 for 3 cycles.
  - Expect pc_write=0 for 3 cycles (IDLE + 2 WAIT), release on the ack cycle, and stall_cycles=3.
- MEM_TIMEOUT=4, load with no ack.
  - Expect ERROR after 4 WAIT cycles, with mem_timeout=1, exmem_hold=1, pc_write=0 held.
  - Expect a reset pulse to clear everything.
- ex_branch_taken=1 with a simultaneous load-use match and id_jump=1.
  - Expect ifid_flush=1, idex_flush=1, pc_write=1.
- Branch taken during freeze.
  - Expect no flush while frozen and the flush on the release cycle.
- Reset asserted in the 2nd WAIT cycle.
  - Expect dmem_req=0 and stall_cycles=0 immediately (async), and FSM IDLE after release.
  - Expect a late ack to be ignored.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: opcodes (common with the decode control
// unit), the data-memory FSM state type, and the rt-usage decode.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } mem_state_t;

  // Only these instructions read rt as a source; ADDI/LW write it instead.
  function automatic logic uses_rt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory request/acknowledge handshake between the pipeline controller
// (master) and the data memory (slave).
interface hazard_ctrl_if;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output dmem_req, output dmem_we, input dmem_ack);
  modport slave  (input dmem_req, input dmem_we, output dmem_ack);
endinterface

// File: rtl/dmem_handshake_fsm.sv
// Data-memory access sequencer: IDLE -> WAIT (req held until ack or timeout)
// -> ERROR (absorbing). Exports freeze for the hazard logic.
module dmem_handshake_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic dmem_we,
  output logic mem_timeout,
  output logic freeze
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WCNT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT > 0);

  mem_state_t    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          we_q, we_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = WAIT;
          wcnt_d  = '0;
          we_d    = mem_write;
        end
      end
      WAIT: begin
        // ack beats a simultaneous timeout
        if (dmem_ack) begin
          state_d = IDLE;
          we_d    = 1'b0;
        end else if (TIMEOUT_EN && wcnt_q == WCNT_LAST) begin
          state_d = ERROR;
          we_d    = 1'b0;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ERROR;
        we_d    = 1'b0;
      end
    endcase
  end

  assign dmem_req    = (state_q == WAIT);
  assign dmem_we     = we_q;
  assign mem_timeout = (state_q == ERROR);
  assign freeze      = ((state_q == IDLE) && (mem_read || mem_write)) ||
                       ((state_q == WAIT) && !dmem_ack) ||
                       (state_q == ERROR);

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencing: memory freeze, branch/jump squash, load-use
// bubble, and a saturating count of cycles the PC was held.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             id_opcode,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_jump,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rt,
  input  logic                   ex_branch_taken,
  input  logic                   mem_read,
  input  logic                   mem_write,
  hazard_ctrl_if.master          dmem,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_write,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_hold,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic freeze, load_use, req, we;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  dmem_handshake_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .dmem_ack    (dmem.dmem_ack),
    .dmem_req    (req),
    .dmem_we     (we),
    .mem_timeout (mem_timeout),
    .freeze      (freeze)
  );

  assign dmem.dmem_req = req;
  assign dmem.dmem_we  = we;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt(id_opcode)));

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_hold = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (freeze) begin
      // everything deferred; a pending branch stays in EX and is seen again
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      exmem_hold = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && (stall_q != {STALL_CNT_W{1'b1}})) stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl (MEM_TIMEOUT=4, 4-bit stall counter so
// saturation is reachable). Expected control vectors are queued per cycle.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO = 4;
  localparam int SW = 4;

  // ctl = {pc, ifid, idex, ifid_fl, idex_fl, hold, req, we, timeout}
  localparam logic [8:0] NORM  = 9'b111_00_0_000;
  localparam logic [8:0] LU    = 9'b001_01_0_000;
  localparam logic [8:0] BR    = 9'b111_11_0_000;
  localparam logic [8:0] JMP   = 9'b111_10_0_000;
  localparam logic [8:0] FRZI  = 9'b000_00_1_000;
  localparam logic [8:0] FRZR  = 9'b000_00_1_100;
  localparam logic [8:0] FRZW  = 9'b000_00_1_110;
  localparam logic [8:0] RELR  = 9'b111_00_0_100;
  localparam logic [8:0] RELW  = 9'b111_00_0_110;
  localparam logic [8:0] RELBR = 9'b111_11_0_100;
  localparam logic [8:0] ERR   = 9'b000_00_1_001;
  localparam logic [8:0] ZERO  = 9'b000_00_0_000;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       jmp, exr;
    logic [4:0] exrt;
    logic       br, mr, mw, ack;
    logic [8:0] ctl;
  } row_t;

  typedef struct packed {
    logic [SW-1:0] stall;
    logic [8:0]    ctl;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_jump = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0;
  logic pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_hold, mem_timeout;
  logic [SW-1:0] stall_cycles;

  hazard_ctrl_if dmem_bus ();

  hazard_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SW)) u_dut (
    .clk(clk), .reset(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_read(mem_read), .mem_write(mem_write),
    .dmem(dmem_bus), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_write(idex_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_hold(exmem_hold), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic [SW-1:0] exp_stall = '0;
  exp_t sb[$];

  function automatic row_t r(input logic rs_, input logic [5:0] op, input logic [4:0] rs,
                             input logic [4:0] rt, input logic jmp, input logic exr,
                             input logic [4:0] exrt, input logic br, input logic mr,
                             input logic mw, input logic ack, input logic [8:0] ctl);
    return '{rst: rs_, op: op, rs: rs, rt: rt, jmp: jmp, exr: exr, exrt: exrt,
             br: br, mr: mr, mw: mw, ack: ack, ctl: ctl};
  endfunction

  function automatic logic [8:0] obs_ctl();
    return {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_hold,
            dmem_bus.dmem_req, dmem_bus.dmem_we, mem_timeout};
  endfunction

  task automatic drive(input row_t s);
    rst = s.rst; id_opcode = s.op; id_rs = s.rs; id_rt = s.rt; id_jump = s.jmp;
    ex_mem_read = s.exr; ex_rt = s.exrt; ex_branch_taken = s.br;
    mem_read = s.mr; mem_write = s.mw; dmem_bus.dmem_ack = s.ack;
  endtask

  task automatic do_reset();
    drive(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = '0;
  endtask

  // expected stall for the next sample follows from the expected pc_write now
  task automatic advance(input row_t s);
    if (s.rst) exp_stall = '0;
    else if (!s.ctl[8] && exp_stall != {SW{1'b1}}) exp_stall = exp_stall + 1'b1;
  endtask

  task automatic test_reset();
    row_t q[$];
    exp_t e;
    q.push_back(r(1, OP_RTYPE, 8, 8, 1, 1, 8, 1, 1, 0, 0, ZERO));
    q.push_back(r(0, OP_RTYPE, 1, 2, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (q[i]) begin
      drive(q[i]);
      if (q[i].rst) exp_stall = '0;
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL reset[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      advance(q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t q[$];
    exp_t e;
    do_reset();
    q.push_back(r(0, OP_RTYPE, 8, 3, 0, 1, 8, 0, 0, 0, 0, LU));   // rs match
    q.push_back(r(0, OP_RTYPE, 8, 3, 0, 0, 8, 0, 0, 0, 0, NORM)); // bubble now in EX
    q.push_back(r(0, OP_RTYPE, 0, 3, 0, 1, 0, 0, 0, 0, 0, NORM)); // ex_rt = $0
    q.push_back(r(0, OP_SW,    3, 8, 0, 1, 8, 0, 0, 0, 0, LU));   // store reads rt
    q.push_back(r(0, OP_LW,    3, 8, 0, 1, 8, 0, 0, 0, 0, NORM)); // load writes rt
    q.push_back(r(0, OP_BEQ,   3, 9, 0, 1, 9, 0, 0, 0, 0, LU));
    q.push_back(r(0, OP_ADDI,  3, 9, 0, 1, 9, 0, 0, 0, 0, NORM));
    q.push_back(r(0, OP_BNE,   9, 4, 0, 1, 9, 0, 0, 0, 0, LU));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL load_use[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      advance(q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    row_t q[$];
    exp_t e;
    do_reset();
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZI));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZW));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZW));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RELW));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM)); // stall stays 3
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL store[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      advance(q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t q[$];
    exp_t e;
    do_reset();
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZI));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, RELR));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZI)); // req must drop between
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, RELR));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL back_to_back[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      advance(q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    row_t q[$];
    exp_t e;
    do_reset();
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZI));
    for (int k = 0; k < TO; k++) q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZR));
    for (int k = 0; k < 16; k++) q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, k[0], ERR));
    q.push_back(r(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (q[i]) begin
      drive(q[i]);
      if (q[i].rst) exp_stall = '0;
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL timeout[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      advance(q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    row_t q[$];
    exp_t e;
    do_reset();
    q.push_back(r(0, OP_RTYPE, 8, 3, 1, 1, 8, 1, 0, 0, 0, BR));   // branch > load-use > jump
    q.push_back(r(0, OP_J,     0, 0, 1, 0, 0, 0, 0, 0, 0, JMP));
    q.push_back(r(0, OP_RTYPE, 8, 3, 1, 1, 8, 0, 0, 0, 0, LU));   // jump deferred
    q.push_back(r(0, OP_RTYPE, 8, 3, 1, 0, 8, 0, 0, 0, 0, JMP));  // jump taken next cycle
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FRZI));         // branch held by freeze
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FRZR));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, RELBR));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL branch[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      advance(q[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    row_t q[$];
    exp_t e;
    do_reset();
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZI));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZW));
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZW)); // 2nd WAIT cycle
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL mid_wait[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      if (i < q.size() - 1) begin
        advance(q[i]);
        @(posedge clk); #1;
      end
    end
    // async reset between edges: req and counter must drop without a clock
    #1 rst = 1'b1;
    exp_stall = '0;
    sb.push_back('{stall: exp_stall, ctl: ZERO});
    #1;
    e = sb.pop_front();
    checks++;
    if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
      errors++;
      $display("FAIL mid_wait_async got ctl=%b stall=%0d want ctl=%b stall=%0d", obs_ctl(), stall_cycles, e.ctl, e.stall);
    end
    @(posedge clk); #1;
    q.delete();
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM)); // late ack ignored in IDLE
    q.push_back(r(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (q[i]) begin
      drive(q[i]);
      sb.push_back('{stall: exp_stall, ctl: q[i].ctl});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({obs_ctl(), stall_cycles} !== {e.ctl, e.stall}) begin
        errors++;
        $display("FAIL after_reset[%0d] got ctl=%b stall=%0d want ctl=%b stall=%0d", i, obs_ctl(), stall_cycles, e.ctl, e.stall);
      end
      advance(q[i]);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    dmem_bus.dmem_ack = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_store();
    test_back_to_back();
    test_timeout();
    test_branch_priority();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
